evu_mux_scheduler: RTL and testbench

// - Time-multiplexes the EVU event muxes across up to NUM_SETS configured event sets (perf-style multiplexing).
// - Drives the per-lane select lines, counts each lane's events over a programmable window, then rotates to the next set.
// - Emits one sample per window ({set index, per-lane counts}) on a valid/ready stream towards the SPU side.
// - Sits between the AXI-Lite config registers (cfg inputs) and the evu_mux instances (sel_line_o / evt_i).

---
 rtl/evu_pkg.sv | 21 ++
 rtl/evu_mux_scheduler_if.sv | 40 ++++
 rtl/evu_sat_counter.sv | 31 +++
 rtl/evu_mux_scheduler.sv | 161 ++++++++++++++++
 tb/tb_evu_mux_scheduler.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/evu_pkg.sv
// Shared types and default sizing for the EVU mux scheduler slice.
package evu_pkg;

    localparam int NUM_LANES_D = 4;
    localparam int NUM_SETS_D  = 4;
    localparam int SEL_W_D     = 4;
    localparam int CNT_W_D     = 16;
    localparam int WIN_W_D     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        COUNT  = 2'd2
    } evu_sched_state_e;

    typedef struct packed {
        logic [$clog2(NUM_SETS_D)-1:0]          set;
        logic [NUM_LANES_D-1:0][CNT_W_D-1:0]    cnt;
    } evu_sample_t;

endpackage

// File: rtl/evu_mux_scheduler_if.sv
// Config, event, select and sample-stream bundle of the mux scheduler.
interface evu_mux_scheduler_if
    import evu_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_D,
    parameter int NUM_SETS  = NUM_SETS_D,
    parameter int SEL_W     = SEL_W_D,
    parameter int CNT_W     = CNT_W_D,
    parameter int WIN_W     = WIN_W_D
);
    localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam int NS_W  = $clog2(NUM_SETS) + 1;

    logic                                enable_i;
    logic [NS_W-1:0]                     num_sets_i;
    logic [WIN_W-1:0]                    window_i;
    logic [NUM_SETS*NUM_LANES*SEL_W-1:0] sel_cfg_i;
    logic [NUM_LANES-1:0]                evt_i;
    logic [NUM_LANES*SEL_W-1:0]          sel_line_o;
    logic                                sample_valid_o;
    logic                                sample_ready_i;
    logic [SET_W-1:0]                    sample_set_o;
    logic [NUM_LANES*CNT_W-1:0]          sample_cnt_o;
    logic [CNT_W-1:0]                    drop_cnt_o;

    modport master (
        output enable_i, num_sets_i, window_i, sel_cfg_i,
        output evt_i, sample_ready_i,
        input  sel_line_o, sample_valid_o, sample_set_o,
        input  sample_cnt_o, drop_cnt_o
    );

    modport slave (
        input  enable_i, num_sets_i, window_i, sel_cfg_i,
        input  evt_i, sample_ready_i,
        output sel_line_o, sample_valid_o, sample_set_o,
        output sample_cnt_o, drop_cnt_o
    );

endinterface

// File: rtl/evu_sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps.
module evu_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] r_q;
    logic [W-1:0] w_nxt;

    always_comb begin
        w_nxt = r_q;
        if (clr_i)
            w_nxt = '0;
        else if (inc_i && !(&r_q))
            w_nxt = r_q + W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_q <= '0;
        else
            r_q <= w_nxt;
    end

    assign q_o = r_q;

endmodule

// File: rtl/evu_mux_scheduler.sv
// Rotates EVU mux selects over event sets, counts lane events per window
// and streams one {set, counts} sample per window.
module evu_mux_scheduler
    import evu_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_D,
    parameter int NUM_SETS  = NUM_SETS_D,
    parameter int SEL_W     = SEL_W_D,
    parameter int CNT_W     = CNT_W_D,
    parameter int WIN_W     = WIN_W_D
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    evu_mux_scheduler_if.slave bus
);
    localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam int NS_W  = $clog2(NUM_SETS) + 1;
    localparam int LSW   = NUM_LANES * SEL_W;
    localparam logic [NS_W-1:0] NS_MAX = NS_W'(NUM_SETS);

    evu_sched_state_e r_state;
    evu_sched_state_e w_next;

    logic [SET_W-1:0] r_set_idx;
    logic [NS_W-1:0]  r_nsets;
    logic [NS_W-1:0]  w_nsets;
    logic [WIN_W-1:0] r_win;
    logic [WIN_W-1:0] w_win;
    logic [WIN_W-1:0] r_wcnt;
    logic [LSW-1:0]   r_sel;
    logic             w_clr;
    logic             w_inc_en;
    logic             w_load;
    logic             w_push;
    logic             w_last;
    logic             w_drop;
    logic             w_accept;
    logic             r_valid;
    logic [SET_W-1:0] r_sset;

    logic [NUM_SETS-1:0][LSW-1:0]       w_cfg;
    logic [NUM_LANES-1:0][CNT_W-1:0]    w_cnt;
    logic [NUM_LANES-1:0][CNT_W-1:0]    w_cnt_fin;
    logic [NUM_LANES-1:0][CNT_W-1:0]    r_scnt;

    assign w_cfg = bus.sel_cfg_i;

    assign w_nsets = (bus.num_sets_i == '0) ? NS_W'(1) :
                     (bus.num_sets_i > NS_MAX) ? NS_MAX :
                     bus.num_sets_i;
    assign w_win   = (bus.window_i == '0) ? WIN_W'(1) : bus.window_i;
    assign w_last  = (r_wcnt == r_win - WIN_W'(1));

    always_comb begin
        w_next   = r_state;
        w_clr    = 1'b1;
        w_inc_en = 1'b0;
        w_load   = 1'b0;
        w_push   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.enable_i)
                    w_next = SWITCH;
            end
            SWITCH: begin
                if (bus.enable_i) begin
                    w_next = COUNT;
                    w_load = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            COUNT: begin
                if (!bus.enable_i) begin
                    w_next = IDLE;
                end else begin
                    w_clr    = 1'b0;
                    w_inc_en = 1'b1;
                    if (w_last) begin
                        w_push = 1'b1;
                        w_next = SWITCH;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_set_idx <= '0;
            r_nsets   <= NS_W'(1);
            r_win     <= WIN_W'(1);
            r_wcnt    <= '0;
            r_sel     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE)
                r_set_idx <= '0;
            if (w_load) begin
                r_sel   <= w_cfg[r_set_idx];
                r_nsets <= w_nsets;
                r_win   <= w_win;
                r_wcnt  <= '0;
            end
            if (w_inc_en)
                r_wcnt <= r_wcnt + WIN_W'(1);
            if (w_push) begin
                if (32'(r_set_idx) + 32'd1 >= 32'(r_nsets))
                    r_set_idx <= '0;
                else
                    r_set_idx <= r_set_idx + SET_W'(1);
            end
        end
    end

    // The pushed count must include the event seen on the last cycle.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        evu_sat_counter #(.W(CNT_W)) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (w_clr),
            .inc_i  (w_inc_en & bus.evt_i[l]),
            .q_o    (w_cnt[l])
        );
        assign w_cnt_fin[l] = (bus.evt_i[l] && !(&w_cnt[l])) ?
                              w_cnt[l] + CNT_W'(1) : w_cnt[l];
    end

    assign w_accept = r_valid & bus.sample_ready_i;
    assign w_drop   = w_push & r_valid & ~bus.sample_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_sset  <= '0;
            r_scnt  <= '0;
        end else if (w_push) begin
            r_valid <= 1'b1;
            r_sset  <= r_set_idx;
            r_scnt  <= w_cnt_fin;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    evu_sat_counter #(.W(CNT_W)) u_drop (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (1'b0),
        .inc_i  (w_drop),
        .q_o    (bus.drop_cnt_o)
    );

    assign bus.sel_line_o     = r_sel;
    assign bus.sample_valid_o = r_valid;
    assign bus.sample_set_o   = r_sset;
    assign bus.sample_cnt_o   = r_scnt;

endmodule

// File: tb/tb_evu_mux_scheduler.sv
// Bench for evu_mux_scheduler: slot-based reference model plus directed cases.
module tb_evu_mux_scheduler;
    import evu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    evu_mux_scheduler_if bus ();
    evu_mux_scheduler_if #(.CNT_W(4)) bus2 ();

    evu_mux_scheduler u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    evu_mux_scheduler #(.CNT_W(4)) u_dut4 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus2.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: slot position (-1 idle, 0 settle, 1..win counting)
    int          m_pos;
    int          m_set;
    int          m_ns;
    int          m_win;
    int          m_drop;
    int          m_pushes;
    int          m_sum  [4];
    int          m_scnt [4];
    logic [15:0] m_sel;
    bit          m_valid;
    int          m_sset;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = -1; m_set = 0; m_ns = 1; m_win = 1;
        m_drop = 0; m_pushes = 0; m_sel = '0;
        m_valid = 0; m_sset = 0;
        for (int l = 0; l < 4; l++) begin
            m_sum[l] = 0; m_scnt[l] = 0;
        end
    endtask

    function automatic int clamp_sets(int v);
        if (v == 0) return 1;
        if (v > 4) return 4;
        return v;
    endfunction

    task automatic model_edge();
        bit acc;
        bit push;
        acc  = m_valid && bus.sample_ready_i;
        push = 0;
        if (m_pos < 0) begin
            if (bus.enable_i) begin
                m_pos = 0; m_set = 0;
            end
        end else if (!bus.enable_i) begin
            m_pos = -1;
        end else if (m_pos == 0) begin
            m_ns  = clamp_sets(int'(bus.num_sets_i));
            m_win = (bus.window_i == 0) ? 1 : int'(bus.window_i);
            m_sel = bus.sel_cfg_i[m_set*16 +: 16];
            for (int l = 0; l < 4; l++) m_sum[l] = 0;
            m_pos = 1;
        end else begin
            for (int l = 0; l < 4; l++)
                m_sum[l] += int'(bus.evt_i[l]);
            if (m_pos == m_win) begin
                push = 1; m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        if (push) begin
            if (m_valid && !acc && m_drop < 65535) m_drop++;
            m_valid = 1;
            m_sset  = m_set;
            for (int l = 0; l < 4; l++)
                m_scnt[l] = (m_sum[l] > 65535) ? 65535 : m_sum[l];
            m_set = (m_set + 1 < m_ns) ? m_set + 1 : 0;
            m_pushes++;
        end else if (acc) begin
            m_valid = 0;
        end
    endtask

    function automatic logic [63:0] exp_cnt();
        logic [63:0] v;
        v = '0;
        for (int l = 0; l < 4; l++) v[l*16 +: 16] = 16'(m_scnt[l]);
        return v;
    endfunction

    task automatic check_all();
        chk("sel_line", 64'(bus.sel_line_o), 64'(m_sel));
        chk("valid", 64'(bus.sample_valid_o), 64'(m_valid));
        chk("drop", 64'(bus.drop_cnt_o), 64'(m_drop));
        if (m_valid) begin
            chk("set", 64'(bus.sample_set_o), 64'(m_sset));
            chk("cnt", bus.sample_cnt_o, exp_cnt());
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int p0;
        int d0;
        bus.enable_i = 0; bus.num_sets_i = '0; bus.window_i = '0;
        bus.sel_cfg_i = '0; bus.evt_i = '0; bus.sample_ready_i = 0;
        bus2.enable_i = 0; bus2.num_sets_i = '0; bus2.window_i = '0;
        bus2.sel_cfg_i = '0; bus2.evt_i = '0; bus2.sample_ready_i = 0;
        model_reset();

        // Reset state
        #12;
        check_all();
        chk("rst_set", 64'(bus.sample_set_o), 64'd0);
        chk("rst_cnt", bus.sample_cnt_o, 64'd0);
        chk("rst_valid4", 64'(bus2.sample_valid_o), 64'd0);
        @(negedge clk);
        rst_n = 1;

        // Two sets, window 4, lane0 event every cycle
        bus.num_sets_i = 3'd2;
        bus.window_i   = 16'd4;
        bus.sel_cfg_i  = {32'h4444_3333, 16'h2222, 16'h1111};
        bus.sample_ready_i = 1;
        bus.evt_i    = 4'b0001;
        bus.enable_i = 1;
        n = 0;
        while (m_pushes < 1 && n < 20) begin
            step(); n++;
        end
        chk("t1_latency", 64'(n), 64'd6);
        chk("t1_sel0", 64'(bus.sel_line_o), 64'h1111);
        chk("t1_set0", 64'(bus.sample_set_o), 64'd0);
        chk("t1_cnt0", bus.sample_cnt_o, 64'd4);
        n = 0;
        while (m_pushes < 2 && n < 20) begin
            step(); n++;
        end
        chk("t1_period", 64'(n), 64'd5);
        chk("t1_sel1", 64'(bus.sel_line_o), 64'h2222);
        chk("t1_set1", 64'(bus.sample_set_o), 64'd1);
        chk("t1_cnt1", bus.sample_cnt_o, 64'd4);
        repeat (6) step();
        chk("t1_drop", 64'(bus.drop_cnt_o), 64'd0);

        // Random events, handshake and config
        bus.sel_cfg_i = {$urandom, $urandom};
        for (int i = 0; i < 120; i++) begin
            bus.evt_i          = 4'($urandom);
            bus.sample_ready_i = 1'($urandom);
            bus.window_i       = 16'($urandom_range(0, 5));
            bus.num_sets_i     = 3'($urandom_range(0, 7));
            bus.enable_i       = ($urandom_range(0, 15) != 0);
            step();
        end

        // Overwrites while consumer stalls
        @(negedge clk);
        rst_n = 0;
        #1 model_reset();
        @(negedge clk);
        rst_n = 1;
        bus.sample_ready_i = 0;
        bus.window_i   = 16'd2;
        bus.num_sets_i = 3'd1;
        bus.enable_i   = 1;
        n = 0;
        while (m_pushes < 3 && n < 40) begin
            bus.evt_i = 4'($urandom);
            step(); n++;
        end
        chk("t2_valid", 64'(bus.sample_valid_o), 64'd1);
        chk("t2_drop", 64'(bus.drop_cnt_o), 64'd2);
        bus.sample_ready_i = 1;
        step();
        chk("t2_valid_fall", 64'(bus.sample_valid_o), 64'd0);

        // Ready exactly on a push cycle
        bus.sample_ready_i = 0;
        n = 0;
        while (!(m_valid && m_pos == m_win) && n < 40) begin
            bus.evt_i = 4'($urandom);
            step(); n++;
        end
        chk("t3_reached", 64'(n < 40), 64'd1);
        d0 = m_drop;
        p0 = m_pushes;
        bus.sample_ready_i = 1;
        step();
        chk("t3_valid", 64'(bus.sample_valid_o), 64'd1);
        chk("t3_drop", 64'(bus.drop_cnt_o), 64'(d0));
        chk("t3_pushed", 64'(m_pushes - p0), 64'd1);

        // Disable mid-window, then restart
        bus.window_i = 16'd6;
        bus.num_sets_i = 3'd3;
        n = 0;
        while (!(m_win == 6 && m_pos == 3) && n < 60) begin
            bus.evt_i = 4'($urandom);
            step(); n++;
        end
        chk("t5_reached", 64'(n < 60), 64'd1);
        bus.enable_i = 0;
        repeat (5) step();
        chk("t5_no_push", 64'(bus.sample_valid_o), 64'd0);
        bus.enable_i = 1;
        p0 = m_pushes;
        n = 0;
        while (m_pushes == p0 && n < 30) begin
            bus.evt_i = 4'($urandom);
            step(); n++;
        end
        chk("t5_restart_set", 64'(bus.sample_set_o), 64'd0);

        // Degenerate config: single set, window 1
        bus.num_sets_i = 3'd0;
        bus.window_i   = 16'd0;
        bus.sel_cfg_i  = {48'h0, 16'hA5C3};
        for (int i = 0; i < 16; i++) begin
            bus.evt_i = 4'($urandom);
            bus.sample_ready_i = 1'($urandom);
            step();
        end
        chk("t6_sel", 64'(bus.sel_line_o), 64'hA5C3);

        // Async reset mid-window
        #2 rst_n = 0;
        #1;
        chk("ar_sel", 64'(bus.sel_line_o), 64'd0);
        chk("ar_valid", 64'(bus.sample_valid_o), 64'd0);
        chk("ar_set", 64'(bus.sample_set_o), 64'd0);
        chk("ar_cnt", bus.sample_cnt_o, 64'd0);
        chk("ar_drop", 64'(bus.drop_cnt_o), 64'd0);
        bus.enable_i = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();

        // Saturation with a 4-bit counter
        bus2.num_sets_i = 3'd1;
        bus2.window_i   = 16'd20;
        bus2.evt_i      = 4'b0001;
        bus2.sample_ready_i = 1;
        bus2.enable_i   = 1;
        n = 0;
        while (!bus2.sample_valid_o && n < 40) begin
            @(negedge clk); n++;
        end
        chk("sat_latency", 64'(n), 64'd22);
        chk("sat_valid", 64'(bus2.sample_valid_o), 64'd1);
        chk("sat_cnt", 64'(bus2.sample_cnt_o), 64'h000F);
        chk("sat_set", 64'(bus2.sample_set_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
